// File: rtl/dpll_sequencer_if.sv
// Bundle between the DPLL search controller and its environment: the host start/result pins, the propagation and decide handshakes, and the assignment-store commands.
// The timeout pin exists only when DPLL_SEQ_WATCHDOG_EN is defined.
interface dpll_sequencer_if #(
    parameter int VAR_W = 5,
    parameter int LVL_W = 5
);
    logic             start;
    logic             busy;
    logic             done;
    logic             sat;
    logic             unsat;
    logic             overflow;
`ifdef DPLL_SEQ_WATCHDOG_EN
    logic             timeout;
`endif
    logic             prop_start;
    logic             prop_done;
    logic             prop_conflict;
    logic             prop_all_sat;
    logic             dec_find;
    logic             dec_ended;
    logic [VAR_W:0]   dec_lit;
    logic             asg_valid;
    logic [VAR_W:0]   asg_lit;
    logic [LVL_W-1:0] asg_level;
    logic             undo_valid;
    logic [LVL_W-1:0] undo_level;
    logic [LVL_W-1:0] level;

    modport master (
`ifdef DPLL_SEQ_WATCHDOG_EN
        output timeout,
`endif
        input  start, prop_done, prop_conflict, prop_all_sat, dec_ended, dec_lit,
        output busy, done, sat, unsat, overflow, prop_start, dec_find,
               asg_valid, asg_lit, asg_level, undo_valid, undo_level, level
    );

    modport slave (
`ifdef DPLL_SEQ_WATCHDOG_EN
        input  timeout,
`endif
        output start, prop_done, prop_conflict, prop_all_sat, dec_ended, dec_lit,
        input  busy, done, sat, unsat, overflow, prop_start, dec_find,
               asg_valid, asg_lit, asg_level, undo_valid, undo_level, level
    );
endinterface

// File: rtl/dpll_sequencer.sv
// DPLL search controller: propagate, decide, chronological backtrack over an internal decision trail.
// Optional watchdog under DPLL_SEQ_WATCHDOG_EN (adds WD_CYCLES and the timeout pin).
module dpll_sequencer #(
    parameter int VAR_W = 5,
    parameter int DEPTH = 16,
    parameter int LVL_W = $clog2(DEPTH) + 1
`ifdef DPLL_SEQ_WATCHDOG_EN
    ,
    parameter int WD_CYCLES = 1024
`endif
) (
    input  logic              clock,
    input  logic              reset,
    dpll_sequencer_if.master  bus
);
    localparam int LIT_W = VAR_W + 1;
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PROP      = 3'd1,
        S_DECIDE    = 3'd2,
        S_WAIT_DEC  = 3'd3,
        S_LAUNCH    = 3'd4,
        S_BACKTRACK = 3'd5,
        S_FLIP_ASG  = 3'd6,
        S_DONE      = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [LIT_W-1:0] stk_lit_q  [DEPTH];
    logic             stk_flip_q [DEPTH];
    logic             busy_q, busy_d, done_q, done_d;
    logic             sat_q, sat_d, unsat_q, unsat_d, ovf_q, ovf_d;
    logic             prop_start_q, prop_start_d, dec_find_q, dec_find_d;
    logic             asg_valid_q, asg_valid_d, undo_valid_q, undo_valid_d;
    logic [LIT_W-1:0] asg_lit_q, asg_lit_d;
    logic [LVL_W-1:0] asg_level_q, asg_level_d, undo_level_q, undo_level_d;
    logic             push_s, flip_s;
    logic [LVL_W-1:0] top_lvl_s;
    logic [IDX_W-1:0] top_idx_s, push_idx_s;

    // Entry i holds decision level i+1, so the top lives at level-1.
    assign top_lvl_s  = level_q - LVL_W'(1);
    assign top_idx_s  = top_lvl_s[IDX_W-1:0];
    assign push_idx_s = level_q[IDX_W-1:0];

`ifdef DPLL_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_CYCLES + 1);
    logic [WD_W-1:0] wd_q;
    logic            timeout_q, timeout_d;
    logic            wd_arm_s;

    assign wd_arm_s = (state_q == S_PROP) || (state_q == S_WAIT_DEC);

    // Dwell counter for the two states that wait on external units.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_q <= WD_W'(0);
        end else if (wd_arm_s && (state_d == state_q)) begin
            wd_q <= wd_q + WD_W'(1);
        end else begin
            wd_q <= WD_W'(0);
        end
    end
    assign bus.timeout = timeout_q;
`endif

    // Next-state and registered-output decode.
    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        sat_d        = sat_q;
        unsat_d      = unsat_q;
        ovf_d        = ovf_q;
        prop_start_d = 1'b0;
        dec_find_d   = dec_find_q;
        asg_valid_d  = 1'b0;
        asg_lit_d    = asg_lit_q;
        asg_level_d  = asg_level_q;
        undo_valid_d = 1'b0;
        undo_level_d = undo_level_q;
        push_s       = 1'b0;
        flip_s       = 1'b0;
`ifdef DPLL_SEQ_WATCHDOG_EN
        timeout_d    = timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d      = S_PROP;
                    prop_start_d = 1'b1;
                    busy_d       = 1'b1;
                    level_d      = LVL_W'(0);
                    sat_d        = 1'b0;
                    unsat_d      = 1'b0;
                    ovf_d        = 1'b0;
`ifdef DPLL_SEQ_WATCHDOG_EN
                    timeout_d    = 1'b0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PROP: begin
                if (!bus.prop_done) begin
                    state_d = S_PROP;
                end else if (bus.prop_conflict) begin
                    state_d = S_BACKTRACK;
                end else if (bus.prop_all_sat) begin
                    state_d = S_DONE;
                    sat_d   = 1'b1;
                end else begin
                    state_d = S_DECIDE;
                end
            end
            S_DECIDE: begin
                if (level_q == LVL_W'(DEPTH)) begin
                    state_d = S_DONE;
                    ovf_d   = 1'b1;
                end else begin
                    state_d    = S_WAIT_DEC;
                    dec_find_d = 1'b1;
                end
            end
            S_WAIT_DEC: begin
                if (bus.dec_ended) begin
                    state_d     = S_LAUNCH;
                    dec_find_d  = 1'b0;
                    push_s      = 1'b1;
                    level_d     = level_q + LVL_W'(1);
                    asg_valid_d = 1'b1;
                    asg_lit_d   = bus.dec_lit;
                    asg_level_d = level_q + LVL_W'(1);
                end else begin
                    state_d = S_WAIT_DEC;
                end
            end
            S_LAUNCH: begin
                state_d      = S_PROP;
                prop_start_d = 1'b1;
            end
            S_BACKTRACK: begin
                if (level_q == LVL_W'(0)) begin
                    state_d = S_DONE;
                    unsat_d = 1'b1;
                end else if (stk_flip_q[top_idx_s]) begin
                    level_d = level_q - LVL_W'(1);
                end else begin
                    state_d      = S_FLIP_ASG;
                    undo_valid_d = 1'b1;
                    undo_level_d = level_q;
                    flip_s       = 1'b1;
                end
            end
            S_FLIP_ASG: begin
                state_d     = S_LAUNCH;
                asg_valid_d = 1'b1;
                asg_lit_d   = stk_lit_q[top_idx_s];
                asg_level_d = level_q;
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef DPLL_SEQ_WATCHDOG_EN
        // Expiry overrides whatever the waiting state decided this cycle.
        if (wd_arm_s && (wd_q == WD_W'(WD_CYCLES - 1))) begin
            state_d     = S_DONE;
            timeout_d   = 1'b1;
            dec_find_d  = 1'b0;
            push_s      = 1'b0;
            level_d     = level_q;
            asg_valid_d = 1'b0;
            asg_lit_d   = asg_lit_q;
            asg_level_d = asg_level_q;
        end else begin
            timeout_d = timeout_d;
        end
`endif
    end

    // Control and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            level_q      <= LVL_W'(0);
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sat_q        <= 1'b0;
            unsat_q      <= 1'b0;
            ovf_q        <= 1'b0;
            prop_start_q <= 1'b0;
            dec_find_q   <= 1'b0;
            asg_valid_q  <= 1'b0;
            asg_lit_q    <= LIT_W'(0);
            asg_level_q  <= LVL_W'(0);
            undo_valid_q <= 1'b0;
            undo_level_q <= LVL_W'(0);
`ifdef DPLL_SEQ_WATCHDOG_EN
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            sat_q        <= sat_d;
            unsat_q      <= unsat_d;
            ovf_q        <= ovf_d;
            prop_start_q <= prop_start_d;
            dec_find_q   <= dec_find_d;
            asg_valid_q  <= asg_valid_d;
            asg_lit_q    <= asg_lit_d;
            asg_level_q  <= asg_level_d;
            undo_valid_q <= undo_valid_d;
            undo_level_q <= undo_level_d;
`ifdef DPLL_SEQ_WATCHDOG_EN
            timeout_q    <= timeout_d;
`endif
        end
    end

    // Decision trail: push a fresh decision or flip the top one in place.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stk_lit_q[i]  <= LIT_W'(0);
                stk_flip_q[i] <= 1'b0;
            end
        end else if (push_s) begin
            stk_lit_q[push_idx_s]  <= bus.dec_lit;
            stk_flip_q[push_idx_s] <= 1'b0;
        end else if (flip_s) begin
            stk_lit_q[top_idx_s]  <= {stk_lit_q[top_idx_s][LIT_W-1:1], ~stk_lit_q[top_idx_s][0]};
            stk_flip_q[top_idx_s] <= 1'b1;
        end else begin
            stk_flip_q[top_idx_s] <= stk_flip_q[top_idx_s];
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.sat        = sat_q;
    assign bus.unsat      = unsat_q;
    assign bus.overflow   = ovf_q;
    assign bus.prop_start = prop_start_q;
    assign bus.dec_find   = dec_find_q;
    assign bus.asg_valid  = asg_valid_q;
    assign bus.asg_lit    = asg_lit_q;
    assign bus.asg_level  = asg_level_q;
    assign bus.undo_valid = undo_valid_q;
    assign bus.undo_level = undo_level_q;
    assign bus.level      = level_q;
endmodule

// File: doc/dpll_sequencer.md
Name: dpll_sequencer

Overview:
- Top-level search controller for the solver core.
- Sequences the propagation unit and the branch-decision unit through one DPLL search: propagate, decide, then on conflict backtrack with chronological flipping.
- Keeps the decision trail in an internal stack.
- Drives assignment and undo commands to the shared assignment store.

Parameters:
- VAR_W, 5, width of a variable number; matches lit.num in common.
- DEPTH, 16, maximum decision levels in the trail stack; power of two ≥ 2.
- LVL_W, $clog2(DEPTH)+1, width of level counters.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous active-low reset; all state clears while low.
- start  in  1  one-cycle pulse in IDLE begins a search; ignored in every other state.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the search ends.
- sat  out  1  valid with done: formula satisfiable.
- unsat  out  1  valid with done: formula unsatisfiable.
- overflow  out  1  valid with done: trail stack full; sat=unsat=0.
- prop_start  out  1  one-cycle pulse to the propagation unit.
- prop_done  in  1  pulse: propagation finished; qualifies the two inputs below.
- prop_conflict  in  1  an empty clause exists.
- prop_all_sat  in  1  every clause is satisfied.
- dec_find  out  1  level request to the decide unit; held until dec_ended.
- dec_ended  in  1  pulse: dec_lit valid this cycle.
- dec_lit  in  VAR_W+1  {num, val} literal chosen by the decide unit.
- asg_valid  out  1  one-cycle pulse: write asg_lit at asg_level.
- asg_lit  out  VAR_W+1  literal to assign.
- asg_level  out  LVL_W  decision level of the assignment.
- undo_valid  out  1  one-cycle pulse: clear every assignment with level ≥ undo_level.
- undo_level  out  LVL_W  level to undo.
- level  out  LVL_W  current decision level (stack occupancy).

Behaviour:
- Reset values: all outputs 0, level=0, stack empty, state IDLE.
- Stack entry is {lit, flipped}. level = number of entries. Entry i sits at decision level i+1.
- States and transitions:
  - IDLE: on start, go to PROP and drive prop_start.
  - PROP: wait for prop_done. Evaluate conflict first.
    - prop_conflict=1: go to BACKTRACK.
    - Else prop_all_sat=1: go to DONE with sat.
    - Else: go to DECIDE.
  - DECIDE: if level==DEPTH, go to DONE with overflow. Otherwise assert dec_find and go to WAIT_DEC.
  - WAIT_DEC: on dec_ended, latch dec_lit, push {dec_lit,0}, and increment level. In the same cycle pulse asg_valid with asg_lit=dec_lit and asg_level=new level. Next cycle drive prop_start and go to PROP.
  - BACKTRACK: one stack entry is examined per cycle.
    - Stack empty: go to DONE with unsat.
    - Top entry flipped=1: pop it and decrement level.
    - Top entry flipped=0: pulse undo_valid with undo_level=level. Replace top with {~val,1}; level unchanged. Next cycle pulse asg_valid with the flipped literal at the current level, then prop_start, then go to PROP.
  - DONE: pulse done with exactly one of sat/unsat/overflow high, then go to IDLE. Result flags hold until the next accepted start.
- Latency: start → prop_start is 1 cycle. dec_ended → prop_start is 2 cycles. A pop costs 1 cycle per level.
- prop_done while not in PROP, or dec_ended while not in WAIT_DEC: ignored.
- prop_conflict and prop_all_sat both high: treated as conflict.
- Before the first decision (level 0) a conflict yields unsat. No undo is issued in that case.
- The asg_valid/undo_valid pair is never high in the same cycle.
- Reset mid-search: immediate return to IDLE; stack emptied; no done pulse.

Optional Feature:
- Macro DPLL_SEQ_WATCHDOG_EN.
- When defined:
  - Adds parameter WD_CYCLES (default 1024).
  - A counter increments every cycle in PROP or WAIT_DEC and clears on state exit.
  - Reaching WD_CYCLES forces DONE with a new output port timeout=1; sat, unsat and overflow stay 0.
- When undefined: no counter, no timeout port; the controller waits indefinitely.

Test Plan:
- Immediate SAT: start; first prop_done has all_sat=1 → done 2 cycles later with sat=1, level=0, no asg_valid.
- Root conflict: start; prop_done with conflict=1 → unsat=1, no undo_valid, level=0.
- Single decision then SAT: prop(no result) → dec_find; dec_lit={3,1} → asg_valid lit {3,1} level 1. Next prop all_sat → sat=1, level=1.
- Flip then UNSAT: decide {2,0}, conflict → undo_level=1 and asg {2,1} at level 1. Second conflict → pop; empty → unsat=1, level=0.
- Overflow: with DEPTH=2, three non-conflict undecided props → done with overflow=1 on the third DECIDE.
- Async reset: drop reset low mid-WAIT_DEC → all outputs 0 within the same cycle, level=0, state IDLE. The next start works normally.
